// File: rtl/timer_entry_ctrl.sv
// timer_entry_ctrl: keypad-side controller for the microwave timer.
// It collects BCD digits into an entry register and parallel-loads them into
// the cascaded mod-10 down-counter chain (load_data/loadn). It then runs the
// chain with cnt_en and watches the chain's all-zero flag for end of cook time.
//
// Ports:
//   clk        in   rising-edge clock
//   clr        in   synchronous active-high reset
//   key_valid  in   strobe: key_digit holds a new keypress (10..15 ignored)
//   key_digit  in   keypad digit
//   key_start  in   strobe: start / resume
//   key_stop   in   strobe: pause / cancel / clear
//   cnt_zero   in   every counter digit in the chain is 0
//   load_data  out  registered entry, most-significant digit in the MSBs
//   loadn      out  registered active-low load strobe to the chain
//   cnt_en     out  count enable to the least-significant counter
//   done       out  cook time expired
//   beep       out  beeper drive
//
// Optional feature: define DONE_BEEP_EN to beep for BEEP_CYCLES cycles on
// expiry and then return to IDLE on its own. Without it, beep is tied to 0
// and DONE holds until a key strobe.
module timer_entry_ctrl #(
  parameter int unsigned NDIGITS     = 4,
  parameter int unsigned BEEP_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   key_valid,
  input  logic [3:0]             key_digit,
  input  logic                   key_start,
  input  logic                   key_stop,
  input  logic                   cnt_zero,
  output logic [4*NDIGITS-1:0]   load_data,
  output logic                   loadn,
  output logic                   cnt_en,
  output logic                   done,
  output logic                   beep
);

  localparam int unsigned W = 4 * NDIGITS;

  if (NDIGITS < 1 || BEEP_CYCLES < 1) begin : g_param_check
    $error("timer_entry_ctrl: NDIGITS and BEEP_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   entry_q, entry_d;
  logic           loadn_q;
  logic           any_key;

`ifdef DONE_BEEP_EN
  localparam int unsigned BW = $clog2(BEEP_CYCLES + 1);
  logic [BW-1:0]  beep_cnt_q, beep_cnt_d;
`endif

  assign any_key = key_valid | key_start | key_stop;

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    unique case (state_q)
      S_IDLE: begin
        if (key_stop) begin
          entry_d = '0;
        end else if (key_start) begin
          if (entry_q != '0) state_d = S_LOAD;
        end else if (key_valid && key_digit <= 4'd9) begin
          entry_d = (entry_q << 4) | W'(key_digit);
        end
      end
      S_LOAD:  state_d = S_RUN;
      S_RUN: begin
        if (cnt_zero)      state_d = S_DONE;
        else if (key_stop) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (key_stop) begin
          state_d = S_IDLE;
          entry_d = '0;
        end else if (key_start) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (any_key) begin
          state_d = S_IDLE;
          entry_d = '0;
        end
`ifdef DONE_BEEP_EN
        // The last beep cycle is the one with the counter at 1; leave DONE
        // on that edge so beep covers exactly BEEP_CYCLES cycles.
        else if (beep_cnt_q <= BW'(1)) begin
          state_d = S_IDLE;
          entry_d = '0;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
        entry_d = '0;
      end
    endcase
  end

`ifdef DONE_BEEP_EN
  always_comb begin
    beep_cnt_d = '0;
    if (state_d == S_DONE) begin
      if (state_q != S_DONE) beep_cnt_d = BW'(BEEP_CYCLES);
      else                   beep_cnt_d = beep_cnt_q - BW'(1);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      entry_q <= '0;
      loadn_q <= 1'b1;
`ifdef DONE_BEEP_EN
      beep_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      entry_q <= entry_d;
      loadn_q <= (state_d != S_LOAD);
`ifdef DONE_BEEP_EN
      beep_cnt_q <= beep_cnt_d;
`endif
    end
  end

  assign load_data = entry_q;
  assign loadn     = loadn_q;
  // Combinational so the chain stops in the same cycle it reaches zero.
  assign cnt_en    = (state_q == S_RUN) && !cnt_zero;
  assign done      = (state_q == S_DONE);
`ifdef DONE_BEEP_EN
  assign beep      = (beep_cnt_q != '0);
`else
  assign beep      = 1'b0;
`endif

endmodule

// File: tb/tb_timer_entry_ctrl.sv
module tb_timer_entry_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        key_valid, key_start, key_stop;
  logic [3:0]  key_digit;
  logic        cnt_zero;
  logic [15:0] load_data;
  logic        loadn, cnt_en, done, beep;

  logic [15:0] chain;
  logic        chain_clr;
  logic        mon_en = 1'b0;

  int unsigned checks = 0;
  int unsigned passes = 0;

  typedef struct {
    string       name;
    logic [19:0] v;   // {load_data, loadn, cnt_en, done, beep}
  } snap_t;

  snap_t       snap_q[$];
  logic [15:0] exp_load_q[$];

  always #5 clk = ~clk;

  timer_entry_ctrl #(.NDIGITS(4), .BEEP_CYCLES(8)) dut (
    .clk(clk), .clr(clr), .key_valid(key_valid), .key_digit(key_digit),
    .key_start(key_start), .key_stop(key_stop), .cnt_zero(cnt_zero),
    .load_data(load_data), .loadn(loadn), .cnt_en(cnt_en), .done(done), .beep(beep)
  );

  // Behavioural model of the external 4-digit BCD down-counter chain.
  function automatic logic [15:0] bcd_dec(input logic [15:0] x);
    logic [15:0] r;
    r = x;
    for (int unsigned i = 0; i < 4; i++) begin
      if (r[4*i +: 4] == 4'd0) begin
        r[4*i +: 4] = 4'd9;
      end else begin
        r[4*i +: 4] = r[4*i +: 4] - 4'd1;
        break;
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (chain_clr)   chain <= '0;
    else if (!loadn) chain <= load_data;
    else if (cnt_en) chain <= bcd_dec(chain);
  end
  assign cnt_zero = (chain == 16'h0000);

  // Monitor: every loadn pulse must match the next expected load; every
  // queued snapshot is compared at the falling edge of its cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (loadn !== 1'b1) begin
        checks++;
        if (exp_load_q.size() == 0) begin
          $display("FAIL unexpected_load: loadn=%b load_data=%h, no load expected", loadn, load_data);
        end else begin
          logic [15:0] e;
          e = exp_load_q.pop_front();
          if (load_data === e) passes++;
          else $display("FAIL load_value: load_data=%h expected %h", load_data, e);
        end
      end
      while (snap_q.size() > 0) begin
        snap_t s;
        logic [19:0] act;
        s = snap_q.pop_front();
        act = {load_data, loadn, cnt_en, done, beep};
        checks++;
        if (act === s.v) passes++;
        else $display("FAIL %s: got ld=%h loadn=%b en=%b done=%b beep=%b, expected ld=%h loadn=%b en=%b done=%b beep=%b",
                      s.name, act[19:4], act[3], act[2], act[1], act[0],
                      s.v[19:4], s.v[3], s.v[2], s.v[1], s.v[0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap(input string n, input logic [15:0] ld, input logic ln, input logic en,
                      input logic dn, input logic bp);
    snap_t s;
    s.name = n;
    s.v    = {ld, ln, en, dn, bp};
    snap_q.push_back(s);
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic start();
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
  endtask

  task automatic stop();
    key_stop = 1'b1;
    tick();
    key_stop = 1'b0;
  endtask

  initial begin
    clr = 1'b1; chain_clr = 1'b1;
    key_valid = 1'b0; key_start = 1'b0; key_stop = 1'b0; key_digit = 4'd0;
    tick(); tick();
    clr = 1'b0; chain_clr = 1'b0;
    mon_en = 1'b1;
    snap("reset", 16'h0000, 1, 0, 0, 0);

    key(1); key(2); key(3); key(0);
    snap("entry_1230", 16'h1230, 1, 0, 0, 0);
    stop();
    snap("stop_clear", 16'h0000, 1, 0, 0, 0);
    key(1); key(2); key(3); key(4); key(5);
    snap("entry_shift_2345", 16'h2345, 1, 0, 0, 0);
    key(4'hC);
    snap("digit_C_ignored", 16'h2345, 1, 0, 0, 0);

    key_stop = 1'b1; key_start = 1'b1;
    tick();
    key_stop = 1'b0; key_start = 1'b0;
    snap("stop_beats_start", 16'h0000, 1, 0, 0, 0);
    tick();
    snap("stop_start_no_load", 16'h0000, 1, 0, 0, 0);
    start();
    snap("start_zero_ignored", 16'h0000, 1, 0, 0, 0);
    tick();
    snap("start_zero_idle", 16'h0000, 1, 0, 0, 0);

    // Run 0005 down to zero.
    key(5);
    snap("entry_0005", 16'h0005, 1, 0, 0, 0);
    exp_load_q.push_back(16'h0005);
    start();
    snap("load_pulse", 16'h0005, 0, 0, 0, 0);
    tick();
    snap("run_5", 16'h0005, 1, 1, 0, 0);
    for (int i = 4; i >= 1; i--) begin
      tick();
      snap($sformatf("run_%0d", i), 16'h0005, 1, 1, 0, 0);
    end
    tick();
    snap("zero_stops_en", 16'h0005, 1, 0, 0, 0);
    tick();
`ifdef DONE_BEEP_EN
    snap("done_beep_1", 16'h0005, 1, 0, 1, 1);
    for (int i = 2; i <= 8; i++) begin
      tick();
      snap($sformatf("done_beep_%0d", i), 16'h0005, 1, 0, 1, 1);
    end
    tick();
    snap("beep_end_idle", 16'h0000, 1, 0, 0, 0);
`else
    snap("done_set", 16'h0005, 1, 0, 1, 0);
    tick(); tick();
    snap("done_held", 16'h0005, 1, 0, 1, 0);
    key(7);
    snap("done_exit_digit_dropped", 16'h0000, 1, 0, 0, 0);
`endif

    // Pause / resume / cancel.
    key(3); key(0);
    exp_load_q.push_back(16'h0030);
    start();
    snap("load_0030", 16'h0030, 0, 0, 0, 0);
    tick();
    snap("run_0030", 16'h0030, 1, 1, 0, 0);
    tick();
    stop();
    snap("pause", 16'h0030, 1, 0, 0, 0);
    tick();
    snap("pause_held", 16'h0030, 1, 0, 0, 0);
    start();
    snap("resume_no_reload", 16'h0030, 1, 1, 0, 0);
    stop();
    snap("pause_again", 16'h0030, 1, 0, 0, 0);
    stop();
    snap("cancel_idle", 16'h0000, 1, 0, 0, 0);

    // Reset in the middle of a run.
    key(9);
    exp_load_q.push_back(16'h0009);
    start();
    snap("load_0009", 16'h0009, 0, 0, 0, 0);
    tick();
    snap("run_0009", 16'h0009, 1, 1, 0, 0);
    clr = 1'b1;
    key_start = 1'b1;
    tick();
    clr = 1'b0;
    key_start = 1'b0;
    snap("clr_in_run", 16'h0000, 1, 0, 0, 0);

    tick();
    @(negedge clk);
    #1;
    checks++;
    if (exp_load_q.size() == 0 && snap_q.size() == 0) passes++;
    else $display("FAIL leftover: %0d loads and %0d snapshots still pending, expected 0",
                  exp_load_q.size(), snap_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
